// File: rtl/frame_buffer_controller_pkg.sv
// Shared types for the frame buffer controller: per-buffer ownership states,
// buffer index type and the saturating drop counter helper.
package BufferControllerTypes;

  localparam int BUF_IDX_W = 2;

  typedef enum logic [2:0] {
    AVAILABLE  = 3'd0,
    WRITE_BUSY = 3'd1,
    UPDATED    = 3'd2,
    READ_BUSY  = 3'd3,
    DISPLAYED  = 3'd4
  } BufferStates;

  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/frame_buffer_controller_if.sv
// Writer/reader handshake bundle between the camera/display clients and the controller.
interface frame_buffer_controller_if #(
  parameter int IDX_W = 2
);
  logic             wr_req, wr_done, wr_drop;
  logic             wr_grant, wr_deny;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_req, rd_done;
  logic             rd_grant;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_empty;
  logic [7:0]       drop_count;
  logic             proto_err;

  modport master (
    output wr_req, wr_done, wr_drop, rd_req, rd_done,
    input  wr_grant, wr_deny, wr_idx, rd_grant, rd_idx, rd_empty, drop_count, proto_err
  );

  modport slave (
    input  wr_req, wr_done, wr_drop, rd_req, rd_done,
    output wr_grant, wr_deny, wr_idx, rd_grant, rd_idx, rd_empty, drop_count, proto_err
  );
endinterface

// File: rtl/frame_buffer_controller_buffer_select.sv
// Priority search: lowest-index buffer whose state matches target.
module buffer_select
  import BufferControllerTypes::*;
#(
  parameter int NUM_BUFFERS = 3
) (
  input  BufferStates [NUM_BUFFERS-1:0] states,
  input  BufferStates                   target,
  output logic                          found,
  output buf_idx_t                      idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (states[i] == target) begin
        found = 1'b1;
        idx   = buf_idx_t'(i);
      end
    end
  end
endmodule

// File: rtl/frame_buffer_controller.sv
// Triple-buffer ownership arbiter between one frame writer and one display reader.
// Same-cycle events resolve as a chain: writer completion, reader release, read, write.
module frame_buffer_controller
  import BufferControllerTypes::*;
#(
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  frame_buffer_controller_if.slave  bus
);
  BufferStates [NUM_BUFFERS-1:0] st_q, s1, s2, s3, s4;

  logic     wb0_found, rb1_found, rb2_found, upd2_found, dsp2_found, wb3_found, av3_found;
  buf_idx_t wb0_idx, rb1_idx, rb2_idx, upd2_idx, dsp2_idx, wb3_idx, av3_idx;

  logic     err_wr, err_rd, err_rq, err_wq, drop_wr, drop_wq;
  logic     wr_grant_d, wr_deny_d, rd_grant_d, rd_empty_d;
  buf_idx_t wr_idx_d, rd_idx_d;

  logic       wr_grant_q, wr_deny_q, rd_grant_q, rd_empty_q, proto_err_q;
  buf_idx_t   wr_idx_q, rd_idx_q;
  logic [7:0] drop_q;

  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_wb0  (.states(st_q), .target(WRITE_BUSY), .found(wb0_found),  .idx(wb0_idx));
  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_rb1  (.states(s1),   .target(READ_BUSY),  .found(rb1_found),  .idx(rb1_idx));
  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_rb2  (.states(s2),   .target(READ_BUSY),  .found(rb2_found),  .idx(rb2_idx));
  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_upd2 (.states(s2),   .target(UPDATED),    .found(upd2_found), .idx(upd2_idx));
  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_dsp2 (.states(s2),   .target(DISPLAYED),  .found(dsp2_found), .idx(dsp2_idx));
  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_wb3  (.states(s3),   .target(WRITE_BUSY), .found(wb3_found),  .idx(wb3_idx));
  buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_sel_av3  (.states(s3),   .target(AVAILABLE),  .found(av3_found),  .idx(av3_idx));

  // Writer completion; a simultaneous done+drop is treated as a drop.
  always_comb begin
    s1      = st_q;
    err_wr  = 1'b0;
    drop_wr = 1'b0;
    if (bus.wr_done || bus.wr_drop) begin
      if (!wb0_found) begin
        err_wr = 1'b1;
      end else if (bus.wr_drop) begin
        drop_wr = 1'b1;
        err_wr  = bus.wr_done;
        for (int i = 0; i < NUM_BUFFERS; i++)
          if (buf_idx_t'(i) == wb0_idx) s1[i] = AVAILABLE;
      end else begin
        for (int i = 0; i < NUM_BUFFERS; i++) begin
          if (s1[i] == UPDATED) s1[i] = AVAILABLE;
          if (buf_idx_t'(i) == wb0_idx) s1[i] = UPDATED;
        end
      end
    end
  end

  always_comb begin
    s2     = s1;
    err_rd = 1'b0;
    if (bus.rd_done) begin
      if (!rb1_found) err_rd = 1'b1;
      else
        for (int i = 0; i < NUM_BUFFERS; i++)
          if (buf_idx_t'(i) == rb1_idx) s2[i] = DISPLAYED;
    end
  end

  // Reader prefers the newest completed frame, else repeats the displayed one.
  always_comb begin
    s3         = s2;
    err_rq     = 1'b0;
    rd_grant_d = 1'b0;
    rd_empty_d = rd_empty_q;
    rd_idx_d   = rd_idx_q;
    if (bus.rd_req) begin
      if (rb2_found) begin
        err_rq = 1'b1;
      end else begin
        rd_grant_d = 1'b1;
        if (upd2_found) begin
          rd_idx_d   = upd2_idx;
          rd_empty_d = 1'b0;
          for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (s2[i] == DISPLAYED) s3[i] = AVAILABLE;
            if (buf_idx_t'(i) == upd2_idx) s3[i] = READ_BUSY;
          end
        end else if (dsp2_found) begin
          rd_idx_d   = dsp2_idx;
          rd_empty_d = 1'b0;
          for (int i = 0; i < NUM_BUFFERS; i++)
            if (buf_idx_t'(i) == dsp2_idx) s3[i] = READ_BUSY;
        end else begin
          rd_empty_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s4         = s3;
    err_wq     = 1'b0;
    drop_wq    = 1'b0;
    wr_grant_d = 1'b0;
    wr_deny_d  = 1'b0;
    wr_idx_d   = wr_idx_q;
    if (bus.wr_req) begin
      if (wb3_found) begin
        err_wq = 1'b1;
      end else if (av3_found) begin
        wr_grant_d = 1'b1;
        wr_idx_d   = av3_idx;
        for (int i = 0; i < NUM_BUFFERS; i++)
          if (buf_idx_t'(i) == av3_idx) s4[i] = WRITE_BUSY;
      end else begin
        wr_deny_d = 1'b1;
        drop_wq   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFFERS; i++) st_q[i] <= AVAILABLE;
      wr_grant_q  <= 1'b0;
      wr_deny_q   <= 1'b0;
      rd_grant_q  <= 1'b0;
      rd_empty_q  <= 1'b1;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      drop_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      st_q        <= s4;
      wr_grant_q  <= wr_grant_d;
      wr_deny_q   <= wr_deny_d;
      rd_grant_q  <= rd_grant_d;
      rd_empty_q  <= rd_empty_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      drop_q      <= sat_add(drop_q, {1'b0, drop_wr} + {1'b0, drop_wq});
      proto_err_q <= proto_err_q | err_wr | err_rd | err_rq | err_wq;
    end
  end

  assign bus.wr_grant   = wr_grant_q;
  assign bus.wr_deny    = wr_deny_q;
  assign bus.wr_idx     = IDX_W'(wr_idx_q);
  assign bus.rd_grant   = rd_grant_q;
  assign bus.rd_idx     = IDX_W'(rd_idx_q);
  assign bus.rd_empty   = rd_empty_q;
  assign bus.drop_count = drop_q;
  assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_frame_buffer_controller.sv
// Scoreboard bench: stimulus pushes expected grant/deny records, monitors pop on each pulse.
module tb_frame_buffer_controller;
  import BufferControllerTypes::*;

  typedef struct packed {
    logic       wg;
    logic       wd;
    logic [1:0] wi;
    logic       rg;
    logic [1:0] ri;
    logic       re;
    logic [7:0] dc;
    logic       pe;
  } resp_t;

  localparam logic [4:0] E_WRQ = 5'b00001, E_RRQ = 5'b00010, E_RDN = 5'b00100,
                         E_WDROP = 5'b01000, E_WDN = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_buffer_controller_if #(.IDX_W(2)) b3 ();
  frame_buffer_controller_if #(.IDX_W(2)) b2 ();

  frame_buffer_controller #(.NUM_BUFFERS(3), .IDX_W(2)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  frame_buffer_controller #(.NUM_BUFFERS(2), .IDX_W(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  resp_t q3[$];
  resp_t q2[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic resp_t mk(logic wg, logic wd, logic [1:0] wi, logic rg, logic [1:0] ri,
                               logic re, logic [7:0] dc, logic pe);
    return {wg, wd, wi, rg, ri, re, dc, pe};
  endfunction

  function automatic resp_t cur(bit on2);
    if (on2) return {b2.wr_grant, b2.wr_deny, b2.wr_idx, b2.rd_grant, b2.rd_idx, b2.rd_empty, b2.drop_count, b2.proto_err};
    return {b3.wr_grant, b3.wr_deny, b3.wr_idx, b3.rd_grant, b3.rd_idx, b3.rd_empty, b3.drop_count, b3.proto_err};
  endfunction

  task automatic check(string nm, resp_t a, resp_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got wg=%0b wd=%0b wi=%0d rg=%0b ri=%0d re=%0b dc=%0d pe=%0b, want wg=%0b wd=%0b wi=%0d rg=%0b ri=%0d re=%0b dc=%0d pe=%0b",
               nm, a.wg, a.wd, a.wi, a.rg, a.ri, a.re, a.dc, a.pe, e.wg, e.wd, e.wi, e.rg, e.ri, e.re, e.dc, e.pe);
    end
  endtask

  task automatic chk_val(string nm, logic [7:0] a, logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask

  task automatic chk_st3(string nm, BufferStates e0, BufferStates e1, BufferStates e2);
    logic [8:0] a, e;
    a = dut3.st_q;
    e = {e2, e1, e0};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: states got %b, want %b", nm, a, e);
    end
  endtask

  task automatic set_in(bit on2, logic [4:0] ev);
    if (on2) begin
      {b2.wr_done, b2.wr_drop, b2.rd_done, b2.rd_req, b2.wr_req} = ev;
    end else begin
      {b3.wr_done, b3.wr_drop, b3.rd_done, b3.rd_req, b3.wr_req} = ev;
    end
  endtask

  task automatic pulse(bit on2, logic [4:0] ev);
    @(posedge clk); #1;
    set_in(on2, ev);
    @(posedge clk); #1;
    set_in(on2, 5'b0);
  endtask

  always @(negedge clk) begin
    if (b3.wr_grant || b3.wr_deny || b3.rd_grant) begin
      if (q3.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut3_unexpected: got wg=%0b wd=%0b rg=%0b, want no pulse", b3.wr_grant, b3.wr_deny, b3.rd_grant);
      end else check("dut3_resp", cur(1'b0), q3.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b2.wr_grant || b2.wr_deny || b2.rd_grant) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut2_unexpected: got wg=%0b wd=%0b rg=%0b, want no pulse", b2.wr_grant, b2.wr_deny, b2.rd_grant);
      end else check("dut2_resp", cur(1'b1), q2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    resp_t rst_r;
    rst_r = mk(0, 0, 0, 0, 0, 1, 0, 0);
    set_in(1'b0, 5'b0);
    set_in(1'b1, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset3", cur(1'b0), rst_r);
    check("reset2", cur(1'b1), rst_r);
    chk_st3("reset_states", AVAILABLE, AVAILABLE, AVAILABLE);
    reset = 1'b0;

    // Empty read before any frame
    q3.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    pulse(1'b0, E_RRQ);
    chk_st3("empty_read_states", AVAILABLE, AVAILABLE, AVAILABLE);

    // First frame written to 0 and displayed
    q3.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    pulse(1'b0, E_WRQ);
    pulse(1'b0, E_WDN);
    q3.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    pulse(1'b0, E_RRQ);
    chk_st3("first_frame_states", READ_BUSY, AVAILABLE, AVAILABLE);

    // Frames into 1 then 2 while reader holds 0; newest wins
    q3.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    pulse(1'b0, E_WRQ);
    pulse(1'b0, E_WDN);
    q3.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0));
    pulse(1'b0, E_WRQ);
    pulse(1'b0, E_WDN);
    chk_st3("newest_wins_states", READ_BUSY, AVAILABLE, UPDATED);
    pulse(1'b0, E_RDN);
    q3.push_back(mk(0, 0, 2, 1, 2, 0, 0, 0));
    pulse(1'b0, E_RRQ);
    chk_st3("read_newest_states", AVAILABLE, AVAILABLE, READ_BUSY);

    // Simultaneous wr_done + rd_done + rd_req
    q3.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0));
    pulse(1'b0, E_WRQ);
    q3.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    pulse(1'b0, E_WDN | E_RDN | E_RRQ);
    chk_st3("same_cycle_states", READ_BUSY, AVAILABLE, AVAILABLE);

    // Repeat frame when nothing new
    pulse(1'b0, E_RDN);
    q3.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    pulse(1'b0, E_RRQ);
    chk_st3("repeat_frame_states", READ_BUSY, AVAILABLE, AVAILABLE);

    // Double wr_req, drop, done+drop
    q3.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    pulse(1'b0, E_WRQ);
    pulse(1'b0, E_WRQ);
    chk_val("proto_err_double_req", 8'(b3.proto_err), 8'd1);
    chk_st3("double_req_states", READ_BUSY, WRITE_BUSY, AVAILABLE);
    pulse(1'b0, E_WDROP);
    chk_val("drop_count_after_drop", b3.drop_count, 8'd1);
    chk_st3("drop_states", READ_BUSY, AVAILABLE, AVAILABLE);
    q3.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1));
    pulse(1'b0, E_WRQ);
    pulse(1'b0, E_WDN | E_WDROP);
    chk_val("drop_count_done_drop", b3.drop_count, 8'd2);
    chk_st3("done_drop_states", READ_BUSY, AVAILABLE, AVAILABLE);
    q3.push_back(mk(1, 0, 1, 0, 0, 0, 2, 1));
    pulse(1'b0, E_WRQ);

    // Reset mid-write, overriding same-cycle requests
    @(posedge clk); #1;
    reset = 1'b1;
    set_in(1'b0, E_WRQ | E_RRQ);
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(1'b0, 5'b0);
    check("reset_mid", cur(1'b0), rst_r);
    chk_st3("reset_mid_states", AVAILABLE, AVAILABLE, AVAILABLE);
    q3.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    pulse(1'b0, E_RRQ);
    pulse(1'b0, E_RDN);
    chk_val("proto_err_orphan_rd_done", 8'(b3.proto_err), 8'd1);

    // Two-buffer instance: deny and saturation
    q2.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    pulse(1'b1, E_WRQ);
    pulse(1'b1, E_WDN);
    q2.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    pulse(1'b1, E_RRQ);
    q2.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    pulse(1'b1, E_WRQ);
    pulse(1'b1, E_WDN);
    q2.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
    pulse(1'b1, E_WRQ);
    for (int k = 2; k <= 257; k++) begin
      q2.push_back(mk(0, 1, 1, 0, 0, 0, 8'((k > 255) ? 255 : k), 0));
      pulse(1'b1, E_WRQ);
    end
    chk_val("drop_count_saturated", b2.drop_count, 8'd255);

    for (int i = 0; i < 20 && (q3.size() + q2.size()) != 0; i++) @(posedge clk);
    n_chk++;
    if ((q3.size() + q2.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses, want 0", q3.size() + q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
